act_writeback: RTL and testbench

Downstream stage of the layer controller in the MLP inference datapath. Takes each finished neuron accumulation, adds bias, applies ReLU for hidden layers, shifts and saturates it to 8 bits, and writes the result into a 16-entry activation buffer. The next layer reads its inputs from this buffer. On the final layer it also tracks the running argmax and reports the winning class.

---
 rtl/act_writeback_pkg.sv | 11 +
 rtl/act_writeback_quant.sv | 21 ++
 rtl/act_writeback.sv | 87 ++++++++
 tb/tb_act_writeback.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/act_writeback_pkg.sv
// act_writeback_pkg: shared widths, FSM state type and saturation bounds for activation writeback
package act_writeback_pkg;
  localparam int DEF_ACC_W = 16;
  localparam int DEF_ACT_W = 8;
  localparam int DEF_SHIFT = 4;
  localparam int DEF_AW    = 4;
  localparam int HID_MAX   = 255;
  localparam int OUT_MIN   = -128;
  localparam int OUT_MAX   = 127;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;
endpackage

// File: rtl/act_writeback_quant.sv
// act_quant: bias add, arithmetic shift, then ReLU+unsigned clamp (hidden) or signed clamp (output); ports acc_sum/bias in, layer_last selects mode, q out
module act_quant
  import act_writeback_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W,
  parameter int ACT_W = DEF_ACT_W,
  parameter int SHIFT = DEF_SHIFT
) (
  input  logic signed [ACC_W-1:0] acc_sum,
  input  logic signed [ACC_W-1:0] bias,
  input  logic                    layer_last,
  output logic [ACT_W-1:0]        q
);
  logic signed [31:0] s, sh;
  always_comb begin
    s  = 32'(acc_sum) + 32'(bias);
    sh = s >>> SHIFT;
    q  = layer_last ? (sh < OUT_MIN ? ACT_W'(OUT_MIN) : sh > OUT_MAX ? ACT_W'(OUT_MAX) : sh[ACT_W-1:0])
                    : (sh < 0 ? '0 : sh > HID_MAX ? ACT_W'(HID_MAX) : sh[ACT_W-1:0]);
  end
endmodule

// File: rtl/act_writeback.sv
// act_writeback: quantize finished neuron sums into a 16-entry activation buffer and track output-layer argmax; ports: acc_* in, act_raddr/act_rdata read port, busy/done_* status
module act_writeback
  import act_writeback_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W,
  parameter int ACT_W = DEF_ACT_W,
  parameter int SHIFT = DEF_SHIFT,
  parameter int AW    = DEF_AW
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    acc_valid,
  input  logic signed [ACC_W-1:0] acc_sum,
  input  logic signed [ACC_W-1:0] bias,
  input  logic [AW-1:0]           acc_idx,
  input  logic                    acc_last,
  input  logic                    layer_last,
  input  logic [AW-1:0]           act_raddr,
  output logic [ACT_W-1:0]        act_rdata,
  output logic                    busy,
  output logic                    done_valid,
  output logic [AW-1:0]           done_class,
  output logic [ACT_W-1:0]        done_score
);
  state_e state_q, state_d;
  logic v1_q, v1_d, last1_q, last1_d, ll1_q, ll1_d, have_q, have_d, we, upd;
  logic [ACT_W-1:0] qv, q1_q, q1_d, max_score_q, max_score_d;
  logic [AW-1:0] idx1_q, idx1_d, max_idx_q, max_idx_d;
  logic [2**AW-1:0][ACT_W-1:0] mem_q, mem_d;
  act_quant #(.ACC_W(ACC_W), .ACT_W(ACT_W), .SHIFT(SHIFT)) u_quant (
    .acc_sum   (acc_sum),
    .bias      (bias),
    .layer_last(layer_last),
    .q         (qv)
  );
  // Quantization happens ahead of stage 1 so the stored byte is ready for the stage-2 write;
  // anything in DONE or coinciding with clr is dropped at either stage.
  always_comb begin
    v1_d        = acc_valid && !clr && state_q != ST_DONE;
    q1_d        = v1_d ? qv : q1_q;
    idx1_d      = v1_d ? acc_idx : idx1_q;
    last1_d     = v1_d ? acc_last : last1_q;
    ll1_d       = v1_d ? layer_last : ll1_q;
    we          = v1_q && !clr && state_q != ST_DONE;
    mem_d       = mem_q;
    if (we) mem_d[idx1_q] = q1_q;
    upd         = we && ll1_q && (!have_q || $signed(q1_q) > $signed(max_score_q));
    have_d      = !clr && (have_q || (we && ll1_q));
    max_score_d = clr ? '0 : upd ? q1_q : max_score_q;
    max_idx_d   = clr ? '0 : upd ? idx1_q : max_idx_q;
    state_d     = clr ? ST_IDLE
                : (state_q == ST_IDLE && acc_valid) ? ST_RUN
                : (state_q == ST_RUN && we && last1_q && ll1_q) ? ST_DONE
                : state_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      v1_q        <= 1'b0;
      q1_q        <= '0;
      idx1_q      <= '0;
      last1_q     <= 1'b0;
      ll1_q       <= 1'b0;
      have_q      <= 1'b0;
      max_score_q <= '0;
      max_idx_q   <= '0;
      mem_q       <= '0;
    end else begin
      state_q     <= state_d;
      v1_q        <= v1_d;
      q1_q        <= q1_d;
      idx1_q      <= idx1_d;
      last1_q     <= last1_d;
      ll1_q       <= ll1_d;
      have_q      <= have_d;
      max_score_q <= max_score_d;
      max_idx_q   <= max_idx_d;
      mem_q       <= mem_d;
    end
  end
  assign act_rdata  = mem_q[act_raddr];
  assign busy       = state_q == ST_RUN;
  assign done_valid = state_q == ST_DONE;
  assign done_class = max_idx_q;
  assign done_score = max_score_q;
endmodule

// File: tb/tb_act_writeback.sv
// tb_act_writeback: directed vector table plus hand-written multi-cycle sequences for act_writeback
module tb_act_writeback;
  logic clk, rst, clr, acc_valid, acc_last, layer_last;
  logic signed [15:0] acc_sum, bias;
  logic [3:0] acc_idx, act_raddr, done_class;
  logic [7:0] act_rdata, done_score;
  logic busy, done_valid;
  int errors = 0;
  int checks = 0;

  act_writeback dut (
    .clk(clk), .rst(rst), .clr(clr), .acc_valid(acc_valid), .acc_sum(acc_sum),
    .bias(bias), .acc_idx(acc_idx), .acc_last(acc_last), .layer_last(layer_last),
    .act_raddr(act_raddr), .act_rdata(act_rdata), .busy(busy),
    .done_valid(done_valid), .done_class(done_class), .done_score(done_score)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  typedef struct {
    bit   ll;
    int   sum;
    int   b;
    int   idx;
    logic [7:0] exp;
  } vec_t;
  vec_t vt[14];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic rd(int a, int exp, string nm);
    act_raddr = 4'(a);
    #1;
    chk(nm, int'(act_rdata), exp);
  endtask

  task automatic send(int s, int b, int idx, bit last, bit ll);
    acc_valid  = 1;
    acc_sum    = 16'(s);
    bias       = 16'(b);
    acc_idx    = 4'(idx);
    acc_last   = last;
    layer_last = ll;
    step();
    acc_valid  = 0;
    acc_last   = 0;
  endtask

  task automatic status(string nm, int b, int dv, int dc, int ds);
    chk({nm, " busy"}, int'(busy), b);
    chk({nm, " done_valid"}, int'(done_valid), dv);
    chk({nm, " done_class"}, int'(done_class), dc);
    chk({nm, " done_score"}, int'(done_score), ds);
  endtask

  initial begin
    vt[0]  = '{0, 100, 20, 3, 8'h07};
    vt[1]  = '{0, -50, 0, 3, 8'h00};
    vt[2]  = '{0, 32767, 32767, 4, 8'hFF};
    vt[3]  = '{0, 4095, 1, 5, 8'hFF};
    vt[4]  = '{0, 4095, 0, 6, 8'hFF};
    vt[5]  = '{0, 16, 0, 7, 8'h01};
    vt[6]  = '{0, 4079, 0, 0, 8'hFE};
    vt[7]  = '{1, -32768, -32768, 8, 8'h80};
    vt[8]  = '{1, 2032, 15, 9, 8'h7F};
    vt[9]  = '{1, 2048, 0, 10, 8'h7F};
    vt[10] = '{1, -2048, 0, 11, 8'h80};
    vt[11] = '{1, -2049, 0, 12, 8'h80};
    vt[12] = '{1, -17, 0, 13, 8'hFE};
    vt[13] = '{1, 100, -40, 14, 8'h03};
    rst = 1; clr = 0; acc_valid = 0; acc_sum = 0; bias = 0;
    acc_idx = 0; acc_last = 0; layer_last = 0; act_raddr = 0;
    step(); step();
    rst = 0;
    status("reset", 0, 0, 0, 0);
    for (int a = 0; a < 16; a++) rd(a, 0, "reset buffer");

    // Vector table: each write observed one edge after the stage-1 capture
    for (int i = 0; i < 14; i++) begin
      send(vt[i].sum, vt[i].b, vt[i].idx, 0, vt[i].ll);
      step();
      rd(vt[i].idx, int'(vt[i].exp), $sformatf("vec%0d", i));
    end
    chk("busy in run", int'(busy), 1);

    // Argmax with tie: earlier index keeps the win
    clr = 1; step(); clr = 0;
    status("after clr", 0, 0, 0, 0);
    send(5 * 16, 0, 0, 0, 1);
    send(9 * 16, 0, 1, 0, 1);
    send(9 * 16, 0, 2, 0, 1);
    send(3 * 16, 0, 3, 1, 1);
    chk("done before T+2", int'(done_valid), 0);
    step();
    status("argmax", 0, 1, 1, 9);
    rd(3, 3, "argmax buf3");
    send(100 * 16, 0, 1, 1, 1);
    step(); step();
    status("ignored in done", 0, 1, 1, 9);
    rd(1, 9, "ignored buf1");

    // First write after clr loads the max unconditionally, even if negative
    clr = 1; step(); clr = 0;
    send(-5 * 16, 0, 0, 0, 1);
    send(-7 * 16, 0, 1, 1, 1);
    step();
    status("neg argmax", 0, 1, 0, 8'hFB);

    // clr coincident with acc_valid drops that entry; earlier data kept
    clr = 1; step(); clr = 0;
    send(160, 0, 2, 0, 0);
    step();
    rd(2, 10, "pre-clr buf2");
    clr = 1;
    send(320, 0, 2, 0, 0);
    clr = 0;
    status("clr coincident", 0, 0, 0, 0);
    step();
    rd(2, 10, "dropped buf2");
    rd(4, 8'hFF, "retained buf4");
    // clr while stage 1 already holds an entry
    send(480, 0, 6, 0, 0);
    clr = 1; step(); clr = 0;
    step();
    rd(6, 8'hFF, "stage1 dropped buf6");
    chk("idle after clr", int'(busy), 0);

    // rst with stage 1 occupied: nothing written, everything zero
    send(160, 0, 9, 0, 0);
    chk("busy before rst", int'(busy), 1);
    rst = 1; step(); rst = 0;
    status("rst mid-op", 0, 0, 0, 0);
    step();
    for (int a = 0; a < 16; a++) rd(a, 0, "post-rst buffer");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
